// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared state encoding and bus constants for the I2C target
package i2c_target_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      WAIT_STOP,
      IGNORE
   } state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync_edge.sv
// rtl/i2c_bus_sync_edge.sv - SCL/SDA synchronizer with edge and START/STOP detection
module i2c_bus_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   // Idle bus level is high, so every stage resets to 1 to avoid phantom edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target with auto-incrementing byte register file
module i2c_target_responder
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         NUM_REGS    = 8,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                        PCLK,
   input  logic                        PRESET,
   input  logic                        SCL_result,
   input  logic                        SDA_result,
   output logic                        SCL_drive,
   output logic                        SDA_drive,
   output logic                        wr_valid,
   output logic [$clog2(NUM_REGS)-1:0] wr_index,
   output logic [7:0]                  wr_data,
   output logic                        busy,
   output logic                        nack_seen
);

   localparam int IW = $clog2(NUM_REGS);

   state_t          state;
   logic [3:0]      bit_cnt;
   logic [7:0]      shift;
   logic [7:0]      rx_byte;
   logic [IW-1:0]   pointer;
   logic            rw;
   logic            ack_phase;
   logic            sda_drv;
   logic [7:0]      regs [NUM_REGS];

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;
   logic sda_s;

   i2c_bus_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (PCLK),
      .rst      (PRESET),
      .scl_in   (SCL_result),
      .sda_in   (SDA_result),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start_det(start_det),
      .stop_det (stop_det),
      .sda_s    (sda_s)
   );

   assign rx_byte   = {shift[6:0], sda_s};
   assign SDA_drive = sda_drv;
   assign SCL_drive = 1'b1;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         pointer   <= '0;
         rw        <= 1'b0;
         ack_phase <= 1'b0;
         sda_drv   <= 1'b1;
         busy      <= 1'b0;
         wr_valid  <= 1'b0;
         wr_index  <= '0;
         wr_data   <= '0;
         nack_seen <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      end else begin
         wr_valid  <= 1'b0;
         nack_seen <= 1'b0;
         if (start_det) begin
            state     <= ADDR;
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            sda_drv   <= 1'b1;
            busy      <= 1'b0;
         end else if (stop_det) begin
            state     <= IDLE;
            ack_phase <= 1'b0;
            sda_drv   <= 1'b1;
            busy      <= 1'b0;
         end else begin
            case (state)
               ADDR, PTR, WR_DATA: begin
                  if (scl_rise) begin
                     shift   <= rx_byte;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        case (state)
                           ADDR: begin
                              if (rx_byte[7:1] == TARGET_ADDR) begin
                                 state <= ADDR_ACK;
                                 busy  <= 1'b1;
                                 rw    <= rx_byte[0];
                              end else begin
                                 state <= IGNORE;
                              end
                           end
                           PTR:     begin
                              pointer <= rx_byte[IW-1:0];
                              state   <= PTR_ACK;
                           end
                           default: state <= WR_ACK;
                        endcase
                     end
                  end
               end

               // First SCL fall starts the ACK low, second one ends it and hands off.
               ADDR_ACK, PTR_ACK, WR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_phase) begin
                        sda_drv   <= I2C_ACK;
                        ack_phase <= 1'b1;
                     end else begin
                        ack_phase <= 1'b0;
                        sda_drv   <= I2C_NACK;
                        if (state == ADDR_ACK && rw) begin
                           state   <= RD_DATA;
                           bit_cnt <= '0;
                           sda_drv <= regs[pointer][7];
                           shift   <= {regs[pointer][6:0], 1'b1};
                        end else if (state == ADDR_ACK) begin
                           state <= PTR;
                        end else if (state == PTR_ACK) begin
                           state <= WR_DATA;
                        end else begin
                           regs[pointer] <= shift;
                           wr_valid      <= 1'b1;
                           wr_index      <= pointer;
                           wr_data       <= shift;
                           pointer       <= pointer + IW'(1);
                           state         <= WR_DATA;
                        end
                     end
                  end
               end

               RD_DATA: begin
                  if (scl_rise) begin
                     if (sda_drv && !sda_s) state <= WAIT_STOP;
                     else bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_drv <= I2C_NACK;
                        bit_cnt <= '0;
                        state   <= RD_ACK;
                     end else begin
                        sda_drv <= shift[7];
                        shift   <= {shift[6:0], 1'b1};
                     end
                  end
               end

               RD_ACK: begin
                  if (scl_rise && !ack_phase) begin
                     if (sda_s == I2C_ACK) begin
                        pointer   <= pointer + IW'(1);
                        ack_phase <= 1'b1;
                     end else begin
                        nack_seen <= 1'b1;
                        state     <= WAIT_STOP;
                     end
                  end else if (scl_fall && ack_phase) begin
                     ack_phase <= 1'b0;
                     state     <= RD_DATA;
                     bit_cnt   <= '0;
                     sda_drv   <= regs[pointer][7];
                     shift     <= {regs[pointer][6:0], 1'b1};
                  end
               end

               default: ;
            endcase
         end
      end
   end

endmodule
